// File: rtl/ntt_stage_sequencer_if.sv
// Handshake bundle between the NTT stage sequencer, the coefficient memory and the butterfly datapath.
// The sequencer takes the master side; the environment (memory, datapath, host) takes the slave side.
interface ntt_stage_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              i_start;
  logic              i_stall;
  logic              i_dp_valid;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr1;
  logic [ADDR_W-1:0] o_rd_addr2;
  logic              o_dp_valid;
  logic [ADDR_W-1:0] o_dp_addr1;
  logic [ADDR_W-1:0] o_dp_addr2;
  logic [9:0]        o_dp_stride;
  logic [8:0]        o_tw_off1;
  logic [8:0]        o_tw_off2;
  logic [8:0]        o_tw_off3;
  logic [8:0]        o_tw_off4;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    input  i_start, i_stall, i_dp_valid,
    output o_rd_en, o_rd_addr1, o_rd_addr2,
    output o_dp_valid, o_dp_addr1, o_dp_addr2, o_dp_stride,
    output o_tw_off1, o_tw_off2, o_tw_off3, o_tw_off4,
    output o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_stall, i_dp_valid,
    input  o_rd_en, o_rd_addr1, o_rd_addr2,
    input  o_dp_valid, o_dp_addr1, o_dp_addr2, o_dp_stride,
    input  o_tw_off1, o_tw_off2, o_tw_off3, o_tw_off4,
    input  o_busy, o_done, o_err
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Walks every row-level stage of the NTT, issuing butterfly pairs to memory and datapath,
// and holds off each following stage until all returns of the current one have drained.
module ntt_stage_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int PIPE_DELAY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_stage_sequencer_if.master bus
);

  localparam int K_W         = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int J_W         = ADDR_W - 1;
  localparam int R_W         = ADDR_W;
  localparam int PAIRS       = 1 << (ADDR_W - 1);
  localparam int DRAIN_LIMIT = RD_LAT + PIPE_DELAY + PAIRS + 8;
  localparam int D_W         = $clog2(DRAIN_LIMIT + 2);

  localparam logic [K_W-1:0] LAST_K    = K_W'(ADDR_W - 1);
  localparam logic [J_W-1:0] LAST_J    = '1;
  localparam logic [R_W-1:0] TERM_R    = R_W'(PAIRS);
  localparam logic [D_W-1:0] D_LIMIT   = D_W'(DRAIN_LIMIT);
  localparam logic [D_W-1:0] D_SAT     = D_W'(DRAIN_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [9:0]        stride;
    logic [8:0]        tw;
  } pair_t;

  state_t          state_q, state_d;
  logic [K_W-1:0]  stage_q, stage_d;
  logic [J_W-1:0]  pairIdx_q, pairIdx_d;
  logic [R_W-1:0]  retCnt_q, retCnt_d;
  logic [D_W-1:0]  drainCnt_q, drainCnt_d;
  logic            err_q, err_d;

  logic            issue;
  logic            beatCounted;
  logic [R_W-1:0]  retNext;
  pair_t           issuePair;
  pair_t           pipe_q [RD_LAT+1];

  int              shiftH;
  logic [31:0]     jWide;
  logic [31:0]     rowStride;
  logic [31:0]     addr1Wide;
  logic [31:0]     twWide;

  // Butterfly pair for (stage, pair index): the pair index gets a zero bit inserted at position H.
  always_comb begin
    shiftH           = ADDR_W - 1 - int'(stage_q);
    jWide            = 32'(pairIdx_q);
    rowStride        = 32'd1 << shiftH;
    addr1Wide        = ((jWide >> shiftH) << (shiftH + 1)) | (jWide & (rowStride - 32'd1));
    twWide           = (32'd1 << stage_q) + (jWide >> shiftH);
    issuePair.valid  = 1'b1;
    issuePair.addr1  = ADDR_W'(addr1Wide);
    issuePair.addr2  = ADDR_W'(addr1Wide + rowStride);
    issuePair.stride = 10'(rowStride << 2);
    issuePair.tw     = 9'(twWide);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      pairIdx_q  <= '0;
      retCnt_q   <= '0;
      drainCnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      pairIdx_q  <= pairIdx_d;
      retCnt_q   <= retCnt_d;
      drainCnt_q <= drainCnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    pairIdx_d   = pairIdx_q;
    retCnt_d    = retCnt_q;
    drainCnt_d  = drainCnt_q;
    err_d       = err_q;
    issue       = 1'b0;

    // Returns overlap issue, so they are counted in both ISSUE and DRAIN; the count saturates at terminal.
    beatCounted = bus.i_dp_valid && (state_q == ISSUE || state_q == DRAIN) && (retCnt_q != TERM_R);
    retNext     = beatCounted ? retCnt_q + R_W'(1) : retCnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          stage_d    = '0;
          pairIdx_d  = '0;
          retCnt_d   = '0;
          drainCnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        retCnt_d = retNext;
        if (!bus.i_stall) begin
          issue     = 1'b1;
          pairIdx_d = pairIdx_q + J_W'(1);
          if (pairIdx_q == LAST_J) begin
            drainCnt_d = '0;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        retCnt_d = retNext;
        if (drainCnt_q != D_SAT) begin
          drainCnt_d = drainCnt_q + D_W'(1);
        end
        if (retNext == TERM_R) begin
          if (stage_q == LAST_K) begin
            state_d = DONE;
          end else begin
            stage_d   = stage_q + K_W'(1);
            pairIdx_d = '0;
            retCnt_d  = '0;
            state_d   = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (bus.i_dp_valid && (state_q == IDLE || state_q == DONE)) begin
      err_d = 1'b1;
    end
    if (bus.i_dp_valid && (state_q == ISSUE || state_q == DRAIN) && (retCnt_q == TERM_R)) begin
      err_d = 1'b1;
    end
    if (state_q == DRAIN && drainCnt_q >= D_LIMIT) begin
      err_d = 1'b1;
    end
    if (state_q == IDLE && bus.i_start) begin
      err_d = 1'b0;
    end
  end

  // Slot 0 drives the memory read; the last slot is the same pair aligned with the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= issue ? issuePair : '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.o_rd_en     = pipe_q[0].valid;
  assign bus.o_rd_addr1  = pipe_q[0].addr1;
  assign bus.o_rd_addr2  = pipe_q[0].addr2;
  assign bus.o_dp_valid  = pipe_q[RD_LAT].valid;
  assign bus.o_dp_addr1  = pipe_q[RD_LAT].addr1;
  assign bus.o_dp_addr2  = pipe_q[RD_LAT].addr2;
  assign bus.o_dp_stride = pipe_q[RD_LAT].stride;
  assign bus.o_tw_off1   = pipe_q[RD_LAT].tw;
  assign bus.o_tw_off2   = pipe_q[RD_LAT].tw;
  assign bus.o_tw_off3   = pipe_q[RD_LAT].tw;
  assign bus.o_tw_off4   = pipe_q[RD_LAT].tw;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer: a 5-cycle echo datapath returns every o_dp_valid beat,
// and a per-negedge monitor records issued pairs, bubbles, returns and completion timing.
module tb_ntt_stage_sequencer;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;
  localparam int PAIRS  = 128;
  localparam int BEATS  = 1024;
  localparam int BOUND  = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_stage_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  ntt_stage_sequencer #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .PIPE_DELAY(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cycleCnt, retCount, rdCount, dpCount, orderViol, modelErr;
  int doneCount, doneCycle, lastRetCycle, busyFallCycle;
  int rdBubbles, dpBubbles, firstRdBubble, firstDpBubble;
  logic [4:0] echoLine;
  logic       injectBeat;

  logic [ADDR_W-1:0] rdA1  [BEATS];
  logic [ADDR_W-1:0] dpA1  [BEATS];
  logic [ADDR_W-1:0] dpA2  [BEATS];
  logic [9:0]        dpStr [BEATS];
  logic [8:0]        dpTw1 [BEATS];
  logic [8:0]        dpTw4 [BEATS];
  int                rdCyc [BEATS];
  int                dpCyc [BEATS];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference pair: low H bits of j, a zero at bit H, the remaining bits of j above it.
  function automatic logic [ADDR_W-1:0] modelAddr1(input int k, input int j);
    int h;
    logic [ADDR_W-1:0] a;
    h = ADDR_W - 1 - k;
    a = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (b < h) a[b] = j[b];
      else if (b > h) a[b] = j[b-1];
    end
    return a;
  endfunction

  function automatic logic [ADDR_W-1:0] modelAddr2(input int k, input int j);
    return modelAddr1(k, j) + ADDR_W'(1 << (ADDR_W - 1 - k));
  endfunction

  function automatic logic [9:0] modelStride(input int k);
    return 10'(4 * (1 << (ADDR_W - 1 - k)));
  endfunction

  function automatic logic [8:0] modelTw(input int k, input int j);
    return 9'((1 << k) + j / (1 << (ADDR_W - 1 - k)));
  endfunction

  task automatic clearMonitor();
    retCount = 0; rdCount = 0; dpCount = 0; orderViol = 0; modelErr = 0;
    doneCount = 0; doneCycle = 0; lastRetCycle = 0; busyFallCycle = 0;
    rdBubbles = 0; dpBubbles = 0; firstRdBubble = 0; firstDpBubble = 0;
  endtask

  // One clock: observe what the last rising edge produced, then drive the echoed return.
  task automatic stepCycle();
    int k, j;
    @(negedge clk);
    cycleCnt++;
    if (bus.i_dp_valid) begin
      retCount++;
      lastRetCycle = cycleCnt - 1;
    end
    if (bus.o_rd_en) begin
      if (retCount < (rdCount / PAIRS) * PAIRS) orderViol++;
      if (rdCount < BEATS) begin
        k = rdCount / PAIRS;
        j = rdCount % PAIRS;
        rdA1[rdCount]  = bus.o_rd_addr1;
        rdCyc[rdCount] = cycleCnt;
        if (bus.o_rd_addr1 !== modelAddr1(k, j) || bus.o_rd_addr2 !== modelAddr2(k, j)) modelErr++;
      end else begin
        modelErr++;
      end
      rdCount++;
    end else if (rdCount > 2 * PAIRS && rdCount < 3 * PAIRS) begin
      rdBubbles++;
      if (firstRdBubble == 0) firstRdBubble = cycleCnt;
    end
    if (bus.o_dp_valid) begin
      if (dpCount < BEATS) begin
        k = dpCount / PAIRS;
        j = dpCount % PAIRS;
        dpA1[dpCount]  = bus.o_dp_addr1;
        dpA2[dpCount]  = bus.o_dp_addr2;
        dpStr[dpCount] = bus.o_dp_stride;
        dpTw1[dpCount] = bus.o_tw_off1;
        dpTw4[dpCount] = bus.o_tw_off4;
        dpCyc[dpCount] = cycleCnt;
        if (bus.o_dp_addr1 !== modelAddr1(k, j) || bus.o_dp_addr2 !== modelAddr2(k, j)) modelErr++;
        if (bus.o_dp_stride !== modelStride(k)) modelErr++;
        if (bus.o_tw_off1 !== modelTw(k, j) || bus.o_tw_off2 !== modelTw(k, j) ||
            bus.o_tw_off3 !== modelTw(k, j) || bus.o_tw_off4 !== modelTw(k, j)) modelErr++;
      end else begin
        modelErr++;
      end
      dpCount++;
    end else if (dpCount > 2 * PAIRS && dpCount < 3 * PAIRS) begin
      dpBubbles++;
      if (firstDpBubble == 0) firstDpBubble = cycleCnt;
    end
    if (bus.o_done) begin
      doneCount++;
      doneCycle = cycleCnt;
    end
    if (!bus.o_busy && doneCount > 0 && busyFallCycle == 0) busyFallCycle = cycleCnt;
    echoLine = {echoLine[3:0], bus.o_dp_valid};
    bus.i_dp_valid = echoLine[4] | injectBeat;
  endtask

  task automatic applyStimulus(input logic start, input logic stall, input int cycles);
    bus.i_start = start;
    bus.i_stall = stall;
    repeat (cycles) stepCycle();
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int n = 0; n < BOUND && doneCount == 0; n++) stepCycle();
    checkOutput(tag, doneCount, 1);
    repeat (3) stepCycle();
  endtask

  task automatic waitRd(input string tag, input int target);
    for (int n = 0; n < BOUND && rdCount < target; n++) stepCycle();
    checkOutput(tag, (rdCount >= target) ? 1 : 0, 1);
  endtask

  task automatic checkCleanRun(input string tag);
    checkOutput({tag, "Beats"}, dpCount, BEATS);
    checkOutput({tag, "RdBeats"}, rdCount, BEATS);
    checkOutput({tag, "Returns"}, retCount, BEATS);
    checkOutput({tag, "Order"}, orderViol, 0);
    checkOutput({tag, "Model"}, modelErr, 0);
    checkOutput({tag, "Err"}, bus.o_err, 0);
    checkOutput({tag, "DoneAfterRet"}, doneCycle - lastRetCycle, 1);
    checkOutput({tag, "BusyFall"}, busyFallCycle - doneCycle, 1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_stall    = 1'b0;
    bus.i_dp_valid = 1'b0;
    injectBeat     = 1'b0;
    echoLine       = '0;
    cycleCnt       = 0;
    clearMonitor();
    repeat (3) stepCycle();

    checkOutput("rstBusy", bus.o_busy, 0);
    checkOutput("rstDone", bus.o_done, 0);
    checkOutput("rstErr", bus.o_err, 0);
    checkOutput("rstRdEn", bus.o_rd_en, 0);
    checkOutput("rstDpValid", bus.o_dp_valid, 0);
    rst = 1'b0;
    stepCycle();

    // Run 1: plain transform, then spot-check addressing against hand values.
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("run1BusyAfterStart", bus.o_busy, 1);
    waitDone("run1Done");
    checkCleanRun("run1");
    checkOutput("run1Bubbles", dpBubbles, 0);
    checkOutput("rdToDpLatency", dpCyc[0] - rdCyc[0], RD_LAT);
    checkOutput("s0j0Addr1", dpA1[0], 0);
    checkOutput("s0j0Addr2", dpA2[0], 128);
    checkOutput("s0j0Stride", dpStr[0], 512);
    checkOutput("s0j0Tw1", dpTw1[0], 1);
    checkOutput("s0j0Tw4", dpTw4[0], 1);
    checkOutput("s0j127Addr1", dpA1[127], 127);
    checkOutput("s0j127Addr2", dpA2[127], 255);
    checkOutput("s0j127RdAddr1", rdA1[127], 127);
    checkOutput("s7j5Addr1", dpA1[901], 10);
    checkOutput("s7j5Addr2", dpA2[901], 11);
    checkOutput("s7j5Stride", dpStr[901], 4);
    checkOutput("s7j5Tw1", dpTw1[901], 133);
    checkOutput("s7j5Tw4", dpTw4[901], 133);

    // Stray return while idle is sticky until the next accepted start.
    injectBeat = 1'b1;
    stepCycle();
    injectBeat = 1'b0;
    stepCycle();
    checkOutput("errIdleBeat", bus.o_err, 1);
    repeat (4) stepCycle();
    checkOutput("errSticky", bus.o_err, 1);

    // Run 2: start clears the error, a start while busy is ignored, stall mid stage 2.
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("errClearedByStart", bus.o_err, 0);
    waitRd("run2ReachJ60", 60);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("busyStartStillBusy", bus.o_busy, 1);
    waitRd("run2ReachStage2", 2 * PAIRS + 40);
    applyStimulus(1'b0, 1'b1, 3);
    waitDone("run2Done");
    checkCleanRun("run2");
    checkOutput("busyStartNoRestart", rdA1[61], 61);
    checkOutput("stallRdBubbles", rdBubbles, 3);
    checkOutput("stallDpBubbles", dpBubbles, 3);
    checkOutput("stallBubbleLag", firstDpBubble - firstRdBubble, RD_LAT);

    // Run 3: reset while stage 3 drains.
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1);
    waitRd("run3ReachStage3Drain", 4 * PAIRS);
    stepCycle();
    checkOutput("midDrainBusy", bus.o_busy, 1);
    rst            = 1'b1;
    bus.i_dp_valid = 1'b0;
    echoLine       = '0;
    #1;
    checkOutput("midRstBusy", bus.o_busy, 0);
    checkOutput("midRstRdEn", bus.o_rd_en, 0);
    checkOutput("midRstRdAddr2", bus.o_rd_addr2, 0);
    checkOutput("midRstDpValid", bus.o_dp_valid, 0);
    checkOutput("midRstDpAddr2", bus.o_dp_addr2, 0);
    checkOutput("midRstStride", bus.o_dp_stride, 0);
    checkOutput("midRstTw1", bus.o_tw_off1, 0);
    checkOutput("midRstDone", bus.o_done, 0);
    checkOutput("midRstErr", bus.o_err, 0);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Run 4: clean transform after the mid-run reset.
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1);
    waitDone("run4Done");
    checkCleanRun("run4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
